// File: rtl/serial_match_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_match_acc: folds a serial stream of per-bit equal flags into a      |
// | per-word result (all-equal, mismatch count, first mismatch index).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_match_acc #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_valid,
  input  logic                       sof,
  input  logic                       equal_in,
  input  logic                       res_ready,
  output logic                       res_valid,
  output logic                       word_equal,
  output logic [$clog2(WIDTH+1)-1:0] mismatch_cnt,
  output logic [$clog2(WIDTH)-1:0]   first_mm_idx,
  output logic                       busy,
  output logic                       overflow
);

  localparam int c_cnt_w = $clog2(WIDTH+1);
  localparam int c_idx_w = $clog2(WIDTH);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WIDTH-1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [c_idx_w-1:0]   r_idx;
  logic                 r_all_eq;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_first;

  logic                 r_res_valid;
  logic                 r_word_equal;
  logic [c_cnt_w-1:0]   r_mm_cnt;
  logic [c_idx_w-1:0]   r_first_idx;
  logic                 r_overflow;

  logic                 w_start;
  logic                 w_accept;
  logic                 w_done;
  logic [c_idx_w-1:0]   w_cur_idx;
  logic                 w_base_eq;
  logic [c_cnt_w-1:0]   w_base_cnt;
  logic [c_idx_w-1:0]   w_base_first;
  logic                 w_new_eq;
  logic [c_cnt_w-1:0]   w_new_cnt;
  logic [c_idx_w-1:0]   w_new_first;

  // A sof bit always restarts from a clean slate, whether idle or mid-word.
  assign w_start      = bit_valid & sof;
  assign w_accept     = bit_valid & (sof | (r_state == ST_ACC));
  assign w_cur_idx    = w_start ? '0 : r_idx;
  assign w_base_eq    = w_start | r_all_eq;
  assign w_base_cnt   = w_start ? '0 : r_cnt;
  assign w_base_first = w_start ? '0 : r_first;

  // First-mismatch index is captured only while the word is still all-equal.
  assign w_new_eq     = w_base_eq & equal_in;
  assign w_new_cnt    = w_base_cnt + c_cnt_w'(!equal_in);
  assign w_new_first  = (w_base_eq & ~equal_in) ? w_cur_idx : w_base_first;
  assign w_done       = w_accept & (w_cur_idx == c_last_idx);

  always_comb begin
    w_next_state = r_state;
    if (w_done) begin
      w_next_state = ST_IDLE;
    end else if (w_accept) begin
      w_next_state = ST_ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_all_eq <= 1'b0;
      r_cnt    <= '0;
      r_first  <= '0;
    end else if (w_done) begin
      r_idx    <= '0;
      r_all_eq <= 1'b0;
      r_cnt    <= '0;
      r_first  <= '0;
    end else if (w_accept) begin
      r_idx    <= w_cur_idx + c_idx_one;
      r_all_eq <= w_new_eq;
      r_cnt    <= w_new_cnt;
      r_first  <= w_new_first;
    end
  end

  // A completing word always wins the result register, taken or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid  <= 1'b0;
      r_word_equal <= 1'b0;
      r_mm_cnt     <= '0;
      r_first_idx  <= '0;
      r_overflow   <= 1'b0;
    end else if (w_done) begin
      r_res_valid  <= 1'b1;
      r_word_equal <= w_new_eq;
      r_mm_cnt     <= w_new_cnt;
      r_first_idx  <= w_new_first;
      if (r_res_valid && !res_ready) begin
        r_overflow <= 1'b1;
      end
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid    = r_res_valid;
  assign word_equal   = r_word_equal;
  assign mismatch_cnt = r_mm_cnt;
  assign first_mm_idx = r_first_idx;
  assign overflow     = r_overflow;
  assign busy         = (r_state == ST_ACC);

endmodule
`default_nettype wire

// File: tb/tb_serial_match_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_match_acc: scoreboard bench for serial_match_acc (WIDTH=8).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serial_match_acc;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);
  localparam int IW = $clog2(W);

  typedef struct packed {
    logic          eq;
    logic [CW-1:0] cnt;
    logic [IW-1:0] first;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_valid;
  logic          sof;
  logic          equal_in;
  logic          res_ready;
  logic          res_valid;
  logic          word_equal;
  logic [CW-1:0] mismatch_cnt;
  logic [IW-1:0] first_mm_idx;
  logic          busy;
  logic          overflow;

  res_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  serial_match_acc #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_valid    (bit_valid),
    .sof          (sof),
    .equal_in     (equal_in),
    .res_ready    (res_ready),
    .res_valid    (res_valid),
    .word_equal   (word_equal),
    .mismatch_cnt (mismatch_cnt),
    .first_mm_idx (first_mm_idx),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: bit i of p is the equal flag of the i-th received bit.
  function automatic res_t model(input logic [W-1:0] p);
    res_t r;
    r.eq = 1'b1;
    r.cnt = '0;
    r.first = '0;
    for (int i = 0; i < W; i++) begin
      if (!p[i]) begin
        if (r.eq) r.first = IW'(i);
        r.eq = 1'b0;
        r.cnt = r.cnt + 1'b1;
      end
    end
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_bit(input logic s, input logic e, input int gap);
    bit_valid = 1'b1;
    sof = s;
    equal_in = e;
    @(negedge clk);
    bit_valid = 1'b0;
    sof = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] p, input int gap, input bit pulse_ready);
    logic old;
    old = res_ready;
    exp_q.push_back(model(p));
    for (int i = 0; i < W; i++) begin
      if (i == W-1 && pulse_ready) res_ready = 1'b1;
      send_bit(i == 0, p[i], (i == W-1) ? 0 : gap);
      if (i == W-1 && pulse_ready) res_ready = old;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [CW+IW+3:0] outs;
    @(negedge clk);
    outs = {res_valid, word_equal, mismatch_cnt, first_mm_idx, busy, overflow};
    n_total++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_equal();
    res_t e;
    res_ready = 1'b1;
    send_word(8'hFF, 0, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (res_valid !== 1'b1) $display("FAIL alleq_valid: got %b want 1", res_valid);
    else n_pass++;
    n_total++;
    if (word_equal !== e.eq) $display("FAIL alleq_word_equal: got %b want %b", word_equal, e.eq);
    else n_pass++;
    n_total++;
    if (mismatch_cnt !== e.cnt) $display("FAIL alleq_cnt: got %0d want %0d", mismatch_cnt, e.cnt);
    else n_pass++;
    n_total++;
    if (first_mm_idx !== e.first) $display("FAIL alleq_first: got %0d want %0d", first_mm_idx, e.first);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL alleq_taken: got res_valid=%b want 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_gaps();
    res_t e;
    res_ready = 1'b1;
    send_word(8'h6B, 2, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (res_valid !== 1'b1) $display("FAIL gaps_valid: got %b want 1", res_valid);
    else n_pass++;
    n_total++;
    if ({word_equal, mismatch_cnt, first_mm_idx} !== {e.eq, e.cnt, e.first})
      $display("FAIL gaps_result: got eq=%b cnt=%0d first=%0d want eq=%b cnt=%0d first=%0d",
               word_equal, mismatch_cnt, first_mm_idx, e.eq, e.cnt, e.first);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    res_t e;
    res_ready = 1'b0;
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b0, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b0, 1'b1, 0);
    n_total++;
    if ({busy, res_valid} !== 2'b10) $display("FAIL abort_partial: got busy/valid=%b want 10", {busy, res_valid});
    else n_pass++;
    send_word(8'h00, 0, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if ({res_valid, busy} !== 2'b10) $display("FAIL abort_valid: got valid/busy=%b want 10", {res_valid, busy});
    else n_pass++;
    n_total++;
    if ({word_equal, mismatch_cnt, first_mm_idx} !== {e.eq, e.cnt, e.first})
      $display("FAIL abort_result: got eq=%b cnt=%0d first=%0d want eq=%b cnt=%0d first=%0d",
               word_equal, mismatch_cnt, first_mm_idx, e.eq, e.cnt, e.first);
    else n_pass++;
    res_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL abort_single: got res_valid=%b want 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    res_t e;
    res_ready = 1'b0;
    send_word(8'hFF, 0, 1'b0);
    n_total++;
    if ({res_valid, overflow} !== 2'b10) $display("FAIL ovf_first: got valid/ovf=%b want 10", {res_valid, overflow});
    else n_pass++;
    send_word(8'hE7, 0, 1'b0);
    void'(exp_q.pop_front()); // first word was overwritten before being taken
    e = exp_q.pop_front();
    n_total++;
    if ({res_valid, overflow} !== 2'b11) $display("FAIL ovf_set: got valid/ovf=%b want 11", {res_valid, overflow});
    else n_pass++;
    n_total++;
    if ({word_equal, mismatch_cnt, first_mm_idx} !== {e.eq, e.cnt, e.first})
      $display("FAIL ovf_result: got eq=%b cnt=%0d first=%0d want eq=%b cnt=%0d first=%0d",
               word_equal, mismatch_cnt, first_mm_idx, e.eq, e.cnt, e.first);
    else n_pass++;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_total++;
    if ({res_valid, overflow} !== 2'b01) $display("FAIL ovf_sticky: got valid/ovf=%b want 01", {res_valid, overflow});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t e;
    do_reset();
    res_ready = 1'b0;
    send_word(8'hBF, 0, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if ({res_valid, word_equal, mismatch_cnt, first_mm_idx} !== {1'b1, e.eq, e.cnt, e.first})
      $display("FAIL b2b_first: got v=%b eq=%b cnt=%0d first=%0d want v=1 eq=%b cnt=%0d first=%0d",
               res_valid, word_equal, mismatch_cnt, first_mm_idx, e.eq, e.cnt, e.first);
    else n_pass++;
    send_word(8'h7F, 0, 1'b1);
    e = exp_q.pop_front();
    n_total++;
    if ({res_valid, overflow} !== 2'b10) $display("FAIL b2b_valid_ovf: got valid/ovf=%b want 10", {res_valid, overflow});
    else n_pass++;
    n_total++;
    if ({word_equal, mismatch_cnt, first_mm_idx} !== {e.eq, e.cnt, e.first})
      $display("FAIL b2b_second: got eq=%b cnt=%0d first=%0d want eq=%b cnt=%0d first=%0d",
               word_equal, mismatch_cnt, first_mm_idx, e.eq, e.cnt, e.first);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    res_t e;
    logic [CW+IW+3:0] outs;
    res_ready = 1'b0;
    send_bit(1'b1, 1'b0, 0);
    for (int i = 1; i < 5; i++) send_bit(1'b0, 1'b1, 0);
    n_total++;
    if ({res_valid, busy} !== 2'b11) $display("FAIL arst_pre: got valid/busy=%b want 11", {res_valid, busy});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1 outs = {res_valid, word_equal, mismatch_cnt, first_mm_idx, busy, overflow};
    n_total++;
    if (outs !== '0) $display("FAIL arst_outputs: got %h want 0", outs);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < W; i++) send_bit(1'b0, 1'b1, 0);
    n_total++;
    if ({busy, res_valid} !== 2'b00) $display("FAIL arst_nosof: got busy/valid=%b want 00", {busy, res_valid});
    else n_pass++;
    send_word(8'hF7, 0, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if ({res_valid, word_equal, mismatch_cnt, first_mm_idx} !== {1'b1, e.eq, e.cnt, e.first})
      $display("FAIL arst_recover: got v=%b eq=%b cnt=%0d first=%0d want v=1 eq=%b cnt=%0d first=%0d",
               res_valid, word_equal, mismatch_cnt, first_mm_idx, e.eq, e.cnt, e.first);
    else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    sof       = 1'b0;
    equal_in  = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_all_equal();
    test_gaps();
    test_abort();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_match_acc.md
SERIAL_MATCH_ACC -- requirements
Module: serial_match_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning number of bits per word (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bit_valid  input  1  equal_in/sof qualify this cycle.
REQ-005 SHALL have port sof  input  1  start-of-word marker, meaningful only with bit_valid.
REQ-006 SHALL have port equal_in  input  1  per-bit equal flag from the upstream 1-bit compare stage.
REQ-007 SHALL have port res_ready  input  1  downstream accepts result when high with res_valid.
REQ-008 SHALL have port res_valid  output  1  result register holds an untaken result.
REQ-009 SHALL have port word_equal  output  1  1 = all WIDTH bits of the word compared equal.
REQ-010 SHALL have port mismatch_cnt  output  $clog2(WIDTH+1)  count of bits with equal_in=0 in the word.
REQ-011 SHALL have port first_mm_idx  output  $clog2(WIDTH)  bit index (0 = first bit received) of first mismatch; 0 when word_equal=1.
REQ-012 SHALL have port busy  output  1  high while in ACC state.
REQ-013 SHALL have port overflow  output  1  sticky: a result was overwritten before being taken.

Function
REQ-014 SHALL implement FSM states IDLE and ACC; accepted bit = bit_valid high at a rising edge.
REQ-015 In IDLE, accepted bit with sof=1 SHALL become bit index 0 and move to ACC; accepted bit with sof=0 SHALL be ignored.
REQ-016 In ACC, accepted bit with sof=0 SHALL become the next index; cycles with bit_valid=0 SHALL hold all accumulator state (gaps allowed, unbounded).
REQ-017 In ACC, accepted bit with sof=1 SHALL discard the partial word and restart at index 0 with that bit, staying in ACC; no result produced for the aborted word.
REQ-018 Accumulators SHALL track running AND of equal_in, count of zeros, and index of first zero (captured once per word).
REQ-019 On acceptance of index WIDTH-1, the final word values (including that bit) SHALL load the result register and the FSM SHALL return to IDLE; res_valid high on the following cycle (latency 1 clock from final bit).
REQ-020 A bit with sof=1 in the cycle following completion SHALL start a new word normally (back-to-back words, no dead cycle).
REQ-021 res_valid SHALL stay high and result outputs stable until a cycle with res_valid and res_ready both high; res_valid SHALL then clear unless a new result loads that same edge.
REQ-022 Completion with res_valid=1 and res_ready=0 SHALL overwrite the result register, keep res_valid=1, and set overflow=1.
REQ-023 Completion with res_valid=1 and res_ready=1 in the same cycle SHALL load the new result, keep res_valid=1, not set overflow.
REQ-024 overflow SHALL clear only by reset.
REQ-025 mismatch_cnt SHALL never exceed WIDTH; word_equal=1 iff mismatch_cnt=0.
REQ-026 busy SHALL equal (state==ACC) registered, no combinational path from inputs.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and clear res_valid, word_equal, mismatch_cnt, first_mm_idx, busy, overflow, and all accumulators to 0.
REQ-028 Reset mid-word SHALL discard the partial word; first accepted bit after release requires sof=1.

Verification (WIDTH=8)
REQ-029 Bench SHALL apply sof+8 bits all equal_in=1, res_ready=1 -> one cycle later res_valid=1, word_equal=1, mismatch_cnt=0, first_mm_idx=0.
REQ-030 Bench SHALL apply equal_in pattern 1,1,0,1,0,1,1,0 with bit_valid gaps of 2 cycles -> word_equal=0, mismatch_cnt=3, first_mm_idx=2.
REQ-031 Bench SHALL apply 5 bits then sof with 8 all-zero bits -> single result, mismatch_cnt=8, first_mm_idx=0, no result for the aborted word.
REQ-032 Bench SHALL hold res_ready=0 across two complete words -> second word's values shown, res_valid=1, overflow=1; then res_ready=1 one cycle -> res_valid=0, overflow stays 1.
REQ-033 Bench SHALL apply two back-to-back words with res_ready pulsed exactly at second completion -> res_valid stays 1, overflow=0.
REQ-034 Bench SHALL assert rst_n=0 asynchronously after bit 4 of a word -> all outputs 0 before the next clock edge; bits with sof=0 after release ignored.
